// File: rtl/steering_slew_ctrl.sv
// steering_slew_ctrl: Avalon-MM slave producing a rate-limited steering
// pulse-width command. The target is clamped to [MIN, MAX], and pwm_width
// moves toward it by at most STEP counts per slew tick.
// Optional feature macro: STEERING_SLEW_WDOG_EN (target-write watchdog that
// falls back to CENTER when software stops writing TARGET).
module steering_slew_ctrl #(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned CENTER       = 300000,
    parameter int unsigned MIN_DEFAULT  = 200000,
    parameter int unsigned MAX_DEFAULT  = 400000,
    parameter int unsigned STEP_DEFAULT = 1000,
    parameter int unsigned WDOG_TICKS   = 100
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [2:0]  avs_ctrl_address,
    input  logic [31:0] avs_ctrl_writedata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic [31:0] avs_ctrl_readdata,
    output logic        avs_ctrl_waitrequest,
    output logic [31:0] pwm_width,
    output logic        at_target
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_TRACK   = 2'b01;
    localparam logic [1:0] ST_SETTLED = 2'b10;

    localparam logic [31:0] ID_VALUE = 32'hEA680004;

    logic [31:0] target_q, step_q, min_q, max_q, cur_q;
    logic        enable_q;
    logic [1:0]  state_q;
    logic [TW-1:0] tick_cnt;
    logic        tick;
    logic        timeout;
    logic [31:0] base, lo_clamped, eff;
    logic [31:0] diff, cur_nxt;
    logic        target_wr;

    assign avs_ctrl_waitrequest = 1'b0;
    assign pwm_width            = cur_q;
    assign target_wr = avs_ctrl_write && (avs_ctrl_address == 3'd1) && (|avs_ctrl_byteenable);

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    // Free-running slew tick divider, independent of FSM state
    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

`ifdef STEERING_SLEW_WDOG_EN
    logic [31:0] wdog_cnt;
    logic        timeout_q;

    // Count active ticks since the last TARGET write; raise TIMEOUT at the limit
    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (target_wr) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (tick && state_q != ST_IDLE && !timeout_q) begin
            wdog_cnt <= wdog_cnt + 32'd1;
            if (wdog_cnt + 32'd1 >= WDOG_TICKS)
                timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
    assign base    = timeout_q ? 32'(CENTER) : target_q;
`else
    assign timeout = 1'b0 & (WDOG_TICKS != 0);
    assign base    = target_q;
`endif

    // Clamp to the window; MAX is applied last so it wins when MIN > MAX
    always_comb begin
        lo_clamped = (base < min_q) ? min_q : base;
        eff        = (lo_clamped > max_q) ? max_q : lo_clamped;
    end

    assign at_target = (cur_q == eff);

    // One slew step: compare first so the subtraction never wraps, and snap to
    // eff when the remaining distance fits in STEP (no overshoot)
    always_comb begin
        diff    = (eff > cur_q) ? (eff - cur_q) : (cur_q - eff);
        cur_nxt = eff;
        if (step_q != 32'd0 && diff > step_q)
            cur_nxt = (eff > cur_q) ? (cur_q + step_q) : (cur_q - step_q);
    end

    // Register file writes, byte-lane merged
    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            target_q <= 32'(CENTER);
            step_q   <= 32'(STEP_DEFAULT);
            min_q    <= 32'(MIN_DEFAULT);
            max_q    <= 32'(MAX_DEFAULT);
            enable_q <= 1'b0;
        end else if (avs_ctrl_write) begin
            case (avs_ctrl_address)
                3'd1: target_q <= be_merge(target_q, avs_ctrl_writedata, avs_ctrl_byteenable);
                3'd2: step_q   <= be_merge(step_q,   avs_ctrl_writedata, avs_ctrl_byteenable);
                3'd3: min_q    <= be_merge(min_q,    avs_ctrl_writedata, avs_ctrl_byteenable);
                3'd4: max_q    <= be_merge(max_q,    avs_ctrl_writedata, avs_ctrl_byteenable);
                3'd6: if (avs_ctrl_byteenable[0]) enable_q <= avs_ctrl_writedata[0];
                default: ;
            endcase
        end
    end

    // Slew FSM; cur only moves on a tick while tracking, and freezes when disabled
    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            state_q <= ST_IDLE;
            cur_q   <= 32'(CENTER);
        end else if (!enable_q) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_q <= ST_TRACK;
                ST_TRACK: begin
                    if (tick) begin
                        cur_q <= cur_nxt;
                        if (cur_nxt == eff) state_q <= ST_SETTLED;
                    end
                end
                ST_SETTLED: if (eff != cur_q) state_q <= ST_TRACK;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // Registered read mux; holds its last value when no read is active
    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            avs_ctrl_readdata <= '0;
        end else if (avs_ctrl_read) begin
            case (avs_ctrl_address)
                3'd0:    avs_ctrl_readdata <= ID_VALUE;
                3'd1:    avs_ctrl_readdata <= target_q;
                3'd2:    avs_ctrl_readdata <= step_q;
                3'd3:    avs_ctrl_readdata <= min_q;
                3'd4:    avs_ctrl_readdata <= max_q;
                3'd5:    avs_ctrl_readdata <= cur_q;
                3'd6:    avs_ctrl_readdata <= {22'd0, state_q, 5'd0, timeout, at_target, enable_q};
                default: avs_ctrl_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_steering_slew_ctrl.sv
// Scoreboard bench for steering_slew_ctrl: register reads push their expected
// value into a queue; a monitor pops and compares when read data comes back.
`timescale 1ns/1ps
module tb_steering_slew_ctrl;

    localparam int unsigned TICK_DIV = 10;
    localparam int unsigned WDOG     = 5;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] rdata;
    logic        waitreq;
    logic [31:0] pwm_width;
    logic        at_target;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tb_cnt = 0;

    steering_slew_ctrl #(
        .TICK_DIV(TICK_DIV), .CENTER(300000), .MIN_DEFAULT(200000),
        .MAX_DEFAULT(400000), .STEP_DEFAULT(1000), .WDOG_TICKS(WDOG)
    ) dut (
        .csi_MCLK_clk(clk), .rsi_MRST_reset(rst),
        .avs_ctrl_address(addr), .avs_ctrl_writedata(wdata),
        .avs_ctrl_byteenable(be), .avs_ctrl_write(wr), .avs_ctrl_read(rd),
        .avs_ctrl_readdata(rdata), .avs_ctrl_waitrequest(waitreq),
        .pwm_width(pwm_width), .at_target(at_target)
    );

    always #5 clk = ~clk;

    // Bench-side tick phase: 0 right after the DUT's tick edge
    always @(posedge clk) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == TICK_DIV - 1) ? 0 : tb_cnt + 1;
    end

    // Monitor: read data is valid just after the edge that samples the read
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rd) begin
                #1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read got %0d (0x%08h) want no read", rdata, rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e.exp || waitreq !== 1'b0) begin
                        errors++;
                        $display("FAIL %s got %0d (0x%08h) want %0d (0x%08h) waitreq %b",
                                 e.name, rdata, rdata, e.exp, e.exp, waitreq);
                    end
                end
            end
        end
    end

    task automatic do_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        addr = a; wdata = d; be = b; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; be = '0;
    endtask

    task automatic do_rd(input logic [2:0] a, input logic [31:0] e, input string n);
        exp_t item;
        item.exp = e; item.name = n;
        exp_q.push_back(item);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic wait_tick();
        do @(negedge clk); while (tb_cnt != 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset values
        do_rd(3'd0, 32'hEA680004, "id");
        do_rd(3'd1, 32'd300000, "rst_target");
        do_rd(3'd2, 32'd1000,   "rst_step");
        do_rd(3'd3, 32'd200000, "rst_min");
        do_rd(3'd4, 32'd400000, "rst_max");
        do_rd(3'd5, 32'd300000, "rst_current");
        do_rd(3'd6, 32'h0000_0002, "rst_status");
        do_rd(3'd7, 32'd0,      "rst_addr7");

        // byte enables and ignored writes
        do_wr(3'd3, 32'd0, 4'b0000);
        do_rd(3'd3, 32'd200000, "min_be_none");
        do_wr(3'd2, 32'hFFFF_FF05, 4'b0001);
        do_rd(3'd2, 32'h0000_0305, "step_be_lane0");
        do_wr(3'd2, 32'd1000, 4'b1111);
        do_wr(3'd7, 32'hFFFF_FFFF, 4'b1111);
        do_rd(3'd7, 32'd0, "addr7_write_ignored");

`ifdef STEERING_SLEW_WDOG_EN
        // watchdog: settle at 210000, then fall back to CENTER after WDOG ticks
        wait_tick();
        do_wr(3'd2, 32'd0, 4'b1111);
        do_wr(3'd1, 32'd210000, 4'b1111);
        do_wr(3'd6, 32'd1, 4'b0001);
        for (int k = 1; k <= 4; k++) wait_tick();
        do_rd(3'd5, 32'd210000, "wd_settled_cur");
        do_rd(3'd6, 32'h0000_0203, "wd_before_timeout");
        wait_tick();
        wait_tick();
        do_rd(3'd5, 32'd300000, "wd_center_cur");
        do_rd(3'd6, 32'h0000_0207, "wd_timeout_status");
        do_wr(3'd1, 32'd210000, 4'b1111);
        wait_tick();
        do_rd(3'd5, 32'd210000, "wd_cleared_cur");
        do_rd(3'd6, 32'h0000_0203, "wd_cleared_status");
`else
        // slew 300000 -> 305500 in 1000-count steps, no overshoot
        wait_tick();
        do_wr(3'd1, 32'd305500, 4'b1111);
        do_wr(3'd6, 32'd1, 4'b0001);
        for (int k = 1; k <= 6; k++) begin
            wait_tick();
            do_rd(3'd5, (k < 6) ? 32'(300000 + 1000 * k) : 32'd305500, $sformatf("slew_tick%0d", k));
        end
        do_rd(3'd6, 32'h0000_0203, "settled_status");

        // MAX clamp, then MAX lowered
        do_wr(3'd1, 32'd500000, 4'b1111);
        for (int k = 0; k < 100; k++) wait_tick();
        do_rd(3'd5, 32'd400000, "clamp_max");
        do_rd(3'd6, 32'h0000_0203, "clamp_max_status");
        do_wr(3'd4, 32'd350000, 4'b1111);
        for (int k = 0; k < 55; k++) wait_tick();
        do_rd(3'd5, 32'd350000, "clamp_max_lowered");

        // STEP=0 jumps straight to target on the first tick
        wait_tick();
        do_wr(3'd2, 32'd0, 4'b1111);
        do_wr(3'd1, 32'd250000, 4'b1111);
        wait_tick();
        do_rd(3'd5, 32'd250000, "step0_jump");

        // disable mid-slew freezes, re-enable resumes
        wait_tick();
        do_wr(3'd2, 32'd1000, 4'b1111);
        do_wr(3'd1, 32'd260000, 4'b1111);
        wait_tick();
        wait_tick();
        do_rd(3'd5, 32'd252000, "midslew_cur");
        do_wr(3'd6, 32'd0, 4'b0001);
        for (int k = 0; k < 3; k++) wait_tick();
        do_rd(3'd5, 32'd252000, "frozen_cur");
        do_rd(3'd6, 32'h0000_0000, "frozen_status");
        do_wr(3'd6, 32'd1, 4'b0001);
        wait_tick();
        do_rd(3'd5, 32'd253000, "resume_cur");
        do_rd(3'd6, 32'h0000_0101, "resume_status");
`endif

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
